// File: rtl/oled_layer_compositor.sv
// oled_layer_compositor
// Merges NUM_LAYERS station pixel streams into one oled_data word by priority
// compositing: layer 0 is on top, and a pixel equal to TRANSPARENT lets the
// layers beneath it show through. The layer-enable mask is latched only at a
// frame start, so a frame never tears. The block also tracks which station
// holds button focus, moved by next/prev pushbuttons.
// Optional feature macro: COMPOSITOR_BLINK_EN blinks the focused layer with a
// period of 2*BLINK_FRAMES frames. Without the macro no frame counter is built.
module oled_layer_compositor #(
  parameter int              NUM_LAYERS   = 4,
  parameter int              PIX_W        = 16,
  parameter logic [PIX_W-1:0] TRANSPARENT = 16'h0000,
  parameter logic [PIX_W-1:0] BG_COLOUR   = 16'h0000,
  parameter int              BLINK_FRAMES = 6,
  localparam int             IDX_W        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                        basys_clk,
  input  logic                        reset,
  input  logic                        frame_begin,
  input  logic [NUM_LAYERS*PIX_W-1:0] layer_pixels,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic                        next_pb,
  input  logic                        prev_pb,
  output logic [PIX_W-1:0]            oled_data,
  output logic [NUM_LAYERS-1:0]       active_mask,
  output logic [NUM_LAYERS-1:0]       focus_onehot,
  output logic [IDX_W-1:0]            focus_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

  // Edge detection
  logic frame_q;
  logic next_q;
  logic prev_q;
  logic frame_start;
  logic next_rise;
  logic prev_rise;

  // Pipeline
  logic [NUM_LAYERS-1:0] opq_next;
  logic [NUM_LAYERS-1:0] s1_opq;
  logic [PIX_W-1:0]      s1_pix [NUM_LAYERS];
  logic                  s1_valid;
  logic [PIX_W-1:0]      comp_pix;
  logic [NUM_LAYERS-1:0] hide_mask;

  assign frame_start = frame_begin & ~frame_q;
  assign next_rise   = next_pb & ~next_q;
  assign prev_rise   = prev_pb & ~prev_q;

  // Registered copies of the level inputs for rising-edge detection
  always_ff @(posedge basys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      frame_q <= 1'b0;
      next_q  <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      frame_q <= frame_begin;
      next_q  <= next_pb;
      prev_q  <= prev_pb;
    end
  end

  // Enable mask takes effect only at a frame start
  always_ff @(posedge basys_clk) begin
    if (reset) begin
      active_mask <= '1;
    end else if (frame_start) begin
      active_mask <= layer_en;
    end
  end

  // Focus cycling; simultaneous next/prev edges cancel, one layer means no movement
  always_ff @(posedge basys_clk) begin
    if (reset) begin
      focus_idx <= '0;
    end else if (NUM_LAYERS > 1) begin
      if (next_rise && !prev_rise) begin
        focus_idx <= (focus_idx == LAST_IDX) ? '0 : focus_idx + 1'b1;
      end else if (prev_rise && !next_rise) begin
        focus_idx <= (focus_idx == '0) ? LAST_IDX : focus_idx - 1'b1;
      end
    end
  end

  assign focus_onehot = NUM_LAYERS'(1) << focus_idx;

`ifdef COMPOSITOR_BLINK_EN
  localparam int CNT_W = (2 * BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BLINK_FRAMES);

  logic [CNT_W-1:0] frame_cnt;
  logic             blink_hide;

  // Frame counter; the hide phase for a frame is taken from the count at its own start
  always_ff @(posedge basys_clk) begin
    if (reset) begin
      frame_cnt  <= '0;
      blink_hide <= 1'b0;
    end else if (frame_start) begin
      blink_hide <= (frame_cnt >= CNT_HALF);
      frame_cnt  <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
    end
  end

  assign hide_mask = blink_hide ? focus_onehot : '0;
`else
  assign hide_mask = '0;
`endif

  // Stage 1 opaque vector: enabled, not the colour key, not blinked out
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    opq_next = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opq_next[i] = active_mask[i] && !hide_mask[i] &&
                    (layer_pixels[i*PIX_W +: PIX_W] != TRANSPARENT);
    end
  end

  // Stage 1 control flops; the valid bit flushes the pipeline after reset
  always_ff @(posedge basys_clk) begin
    if (reset) begin
      s1_opq   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_opq   <= opq_next;
      s1_valid <= 1'b1;
    end
  end

  // Stage 1 pixel data
  always_ff @(posedge basys_clk) begin
    // NOTE: pixel data carries no reset; s1_valid keeps stale words from reaching the output.
    for (int i = 0; i < NUM_LAYERS; i++) begin
      s1_pix[i] <= layer_pixels[i*PIX_W +: PIX_W];
    end
  end

  // Stage 2 priority select: lowest opaque index wins, else background
  always_comb begin
    comp_pix = BG_COLOUR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (s1_opq[i]) comp_pix = s1_pix[i];
    end
  end

  // Stage 2 output register
  always_ff @(posedge basys_clk) begin
    if (reset) begin
      oled_data <= '0;
    end else begin
      oled_data <= s1_valid ? comp_pix : '0;
    end
  end

endmodule

// File: tb/tb_oled_layer_compositor.sv
// Directed bench for oled_layer_compositor: priority vectors from a table,
// then frame-latch, focus and mid-frame reset sequences.
module tb_oled_layer_compositor;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           frame_begin;
  logic [N*W-1:0] layer_pixels;
  logic [N-1:0]   layer_en;
  logic           next_pb;
  logic           prev_pb;
  logic [W-1:0]   oled_data;
  logic [N-1:0]   active_mask;
  logic [N-1:0]   focus_onehot;
  logic [1:0]     focus_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  oled_layer_compositor #(
    .NUM_LAYERS  (N),
    .PIX_W       (W),
    .TRANSPARENT (16'h0000),
    .BG_COLOUR   (16'hFFFF),
    .BLINK_FRAMES(6)
  ) dut (
    .basys_clk   (clk),
    .reset       (reset),
    .frame_begin (frame_begin),
    .layer_pixels(layer_pixels),
    .layer_en    (layer_en),
    .next_pb     (next_pb),
    .prev_pb     (prev_pb),
    .oled_data   (oled_data),
    .active_mask (active_mask),
    .focus_onehot(focus_onehot),
    .focus_idx   (focus_idx)
  );

  typedef struct {
    logic [N-1:0]   mask;
    logic [N*W-1:0] pix;   // {L3, L2, L1, L0}
    logic [W-1:0]   exp_oled;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic focus_check(input string name, input logic [1:0] exp_idx);
    check({name, " idx"}, W'(focus_idx), W'(exp_idx));
    check({name, " onehot"}, W'(focus_onehot), W'(4'b0001 << exp_idx));
  endtask

  initial begin
    vecs[0] = '{4'b1111, {16'hF800, 16'h07E0, 16'h001F, 16'h0000}, 16'h001F};
    vecs[1] = '{4'b1111, {16'hF800, 16'h07E0, 16'h1234, 16'hABCD}, 16'hABCD};
    vecs[2] = '{4'b1110, {16'hF800, 16'h07E0, 16'h1234, 16'hABCD}, 16'h1234};
    vecs[3] = '{4'b1100, {16'hF800, 16'h07E0, 16'h1234, 16'hABCD}, 16'h07E0};
    vecs[4] = '{4'b1000, {16'hF800, 16'h07E0, 16'h1234, 16'hABCD}, 16'hF800};
    vecs[5] = '{4'b0000, {16'hF800, 16'h07E0, 16'h1234, 16'hABCD}, 16'hFFFF};
    vecs[6] = '{4'b1111, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'hFFFF};
    vecs[7] = '{4'b0101, {16'hF800, 16'h07E0, 16'h001F, 16'h0000}, 16'h07E0};
    vecs[8] = '{4'b1010, {16'hF800, 16'h07E0, 16'h001F, 16'h0000}, 16'h001F};

    reset        = 1'b1;
    frame_begin  = 1'b0;
    layer_pixels = '0;
    layer_en     = '0;
    next_pb      = 1'b0;
    prev_pb      = 1'b0;
    tick();
    tick();

    // Reset state
    check("reset oled", oled_data, 16'h0000);
    check("reset mask", W'(active_mask), 16'h000F);
    focus_check("reset focus", 2'd0);
    reset = 1'b0;
    tick();
    tick();

    // Priority table: frame start loads the mask, pixels follow, result two edges later
    for (int v = 0; v < 9; v++) begin
      frame_begin = 1'b1;
      layer_en    = vecs[v].mask;
      tick();
      frame_begin  = 1'b0;
      layer_pixels = vecs[v].pix;
      tick();
      tick();
      check($sformatf("vec%0d mask", v), W'(active_mask), W'(vecs[v].mask));
      check($sformatf("vec%0d oled", v), oled_data, vecs[v].exp_oled);
    end

    // Frame latch: a mid-frame enable change waits for the next frame start
    frame_begin = 1'b1;
    layer_en    = 4'b1111;
    tick();
    frame_begin  = 1'b0;
    layer_pixels = {16'hF800, 16'h07E0, 16'h001F, 16'hABCD};
    layer_en     = 4'b1110;
    tick();
    tick();
    tick();
    check("latch hold mask", W'(active_mask), 16'h000F);
    check("latch hold oled", oled_data, 16'hABCD);
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
    check("latch new mask", W'(active_mask), 16'h000E);
    check("latch old oled", oled_data, 16'hABCD);
    tick();
    tick();
    check("latch new oled", oled_data, 16'h001F);

    // Focus: four next pulses wrap 1,2,3,0
    for (int k = 0; k < 4; k++) begin
      next_pb = 1'b1;
      tick();
      focus_check($sformatf("next%0d", k), 2'((k + 1) % 4));
      next_pb = 1'b0;
      tick();
    end
    // prev from 0 wraps to 3
    prev_pb = 1'b1;
    tick();
    focus_check("prev wrap", 2'd3);
    prev_pb = 1'b0;
    tick();
    // Both edges together: no move
    next_pb = 1'b1;
    prev_pb = 1'b1;
    tick();
    focus_check("both edges", 2'd3);
    next_pb = 1'b0;
    prev_pb = 1'b0;
    tick();
    // Held level gives one step only
    next_pb = 1'b1;
    tick();
    tick();
    tick();
    focus_check("held next", 2'd0);
    next_pb = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      next_pb = 1'b1;
      tick();
      next_pb = 1'b0;
      tick();
    end
    focus_check("focus to 2", 2'd2);

    // Mid-frame reset with focus 2 and mask 0011
    frame_begin = 1'b1;
    layer_en    = 4'b0011;
    tick();
    frame_begin  = 1'b0;
    layer_pixels = {16'hF800, 16'h07E0, 16'h001F, 16'h1357};
    tick();
    tick();
    check("pre-reset mask", W'(active_mask), 16'h0003);
    check("pre-reset oled", oled_data, 16'h1357);
    reset = 1'b1;
    tick();
    check("mid reset oled", oled_data, 16'h0000);
    check("mid reset mask", W'(active_mask), 16'h000F);
    focus_check("mid reset focus", 2'd0);
    reset = 1'b0;
    tick();
    check("flush oled 1", oled_data, 16'h0000);
    tick();
    check("post reset oled", oled_data, 16'h1357);
    // First frame start after reset loads normally
    frame_begin = 1'b1;
    layer_en    = 4'b1100;
    tick();
    frame_begin = 1'b0;
    check("post reset fs mask", W'(active_mask), 16'h000C);
    tick();
    tick();
    check("post reset fs oled", oled_data, 16'h07E0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
